puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Host-side controller that sits directly around puf_serial.
- Drives challenge and RO enable into puf_serial; waits for its byte-ready flag; captures the 8-bit response; pulses the acknowledge/reset back to it.
- Steps through a run of consecutive challenges.
- Responses go into a small FIFO and leave on a valid/ready stream to the host link (UART TX packer).

Parameters:
- FIFO_DEPTH, 4, response FIFO entries (power of two, ≥2).
- ACK_CYCLES, 2, width in clocks of each puf_reset pulse between challenges (≥1).
- TIMEOUT_CYCLES, 1048576, max clocks in RUN waiting for puf_done before abort.

Ports:
- clock in 1: single system clock.
- reset in 1: synchronous, active-high.
- start in 1: one-cycle request; sampled only in IDLE.
- base_challenge in 8: first challenge of the run; latched on start.
- num_challenges in 8: run length; latched on start; 0 = empty run.
- enable_mask in 32: RO enable pattern; latched on start.
- puf_challenge out 8: challenge to puf_serial.
- puf_enable out 32: RO enables to puf_serial.
- puf_reset out 1: ack/reset to puf_serial.
- puf_response in 8: response byte from puf_serial.
- puf_done in 1: byte-ready level from puf_serial; synchronous to clock.
- resp_data out 8: FIFO head.
- resp_valid out 1: FIFO non-empty.
- resp_ready in 1: consumer accepts head when valid&ready.
- busy out 1: high in any state except IDLE.
- seq_done out 1: one-cycle pulse when a run completes normally.
- timeout_err out 1: sticky; set on timeout; cleared on next accepted start or reset.

Behaviour:
- Reset values:
  - state = IDLE; FIFO empty.
  - resp_valid = busy = seq_done = timeout_err = 0.
  - puf_challenge = 0, puf_enable = 0.
  - puf_reset = 1: asserted the same cycle reset is high and held in IDLE.
- States: IDLE, ACK, RUN, CAPTURE, ERR.
- IDLE:
  - puf_reset = 1, puf_enable = 0.
  - start=1 latches base/count/mask and clears timeout_err.
  - count == 0: seq_done pulses next cycle; stays IDLE.
  - Otherwise: load cur_chal = base, remaining = count, then go to ACK.
- ACK:
  - puf_reset = 1, puf_enable = 0, puf_challenge = cur_chal.
  - Stays exactly ACK_CYCLES clocks, then goes to RUN.
- RUN:
  - puf_reset = 0, puf_enable = mask; timeout counter increments each clock.
  - puf_done=1 → CAPTURE.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without puf_done → ERR.
  - puf_done on the same cycle as the timeout limit: puf_done wins.
- CAPTURE:
  - Outputs held as in RUN.
  - Push puf_response when FIFO has space: count < FIFO_DEPTH, or a pop in the same cycle.
  - FIFO full with no pop: stall in CAPTURE; PUF is not reset, so the response stays held.
  - On push, remaining == 1: seq_done pulses; go to IDLE.
  - On push, otherwise: remaining--, cur_chal++ (8-bit wrap, 0xFF → 0x00), go to ACK.
- ERR:
  - timeout_err = 1; puf_reset = 1; puf_enable = 0.
  - Stays one cycle, then goes to IDLE.
  - FIFO contents are kept.
- Latency per challenge:
  - ACK_CYCLES + 1 (RUN entry) + wait for puf_done + 1 (CAPTURE).
  - With ACK_CYCLES=2 and puf_done seen on the 5th RUN cycle: push occurs 8 clocks after ACK entry.
- FIFO:
  - Show-ahead: resp_data is valid while resp_valid.
  - Simultaneous push and pop is allowed at any occupancy.
  - Pop when empty is ignored.
- start while busy: ignored, no effect.
- reset mid-run: next clock returns to the reset values; FIFO is flushed; no seq_done.
- Timeout counter: clears on every RUN entry; width $clog2(TIMEOUT_CYCLES).

Decomposition:
- Shared puf_pkg holds:
  - seq_state_t enum (IDLE, ACK, RUN, CAPTURE, ERR).
  - CHAL_W = 8, RESP_W = 8, RO_COUNT = 32.
  - Default parameter constants.
- Sub-module resp_fifo:
  - Synchronous FIFO with push/pop/full/empty/count.
  - Parameterised depth and width.
  - Instantiated once.
- FSM and counters stay in puf_challenge_sequencer.

Test Plan:
- Single challenge: base=0x3C, count=1, mask=0xFFFFFFFF; fake PUF raises puf_done 10 clocks into RUN with response 0xA5.
  - Expect puf_challenge=0x3C, puf_reset low for 11 clocks.
  - Expect resp_data=0xA5, resp_valid=1, one seq_done pulse; busy falls with it.
- Wrap and sequence: base=0xFE, count=3, responses 0x11, 0x22, 0x33.
  - Expect challenges 0xFE, 0xFF, 0x00.
  - Expect a puf_reset pulse exactly 2 clocks wide before each.
  - Expect FIFO to read out 0x11, 0x22, 0x33 in order.
- Backpressure: count=6, resp_ready=0.
  - Expect 4 pushes, then stall in CAPTURE with puf_reset=0 and the 5th response held.
  - Raise resp_ready for 1 cycle: 5th push is accepted in the same cycle as the pop.
- Timeout: TIMEOUT_CYCLES=16, puf_done never asserted.
  - Expect ERR after 16 RUN clocks, timeout_err=1 sticky, no seq_done, return to IDLE.
  - The next start clears timeout_err.
- Edge cases:
  - count=0: seq_done pulses the next cycle and puf_reset never drops.
  - start asserted while busy: ignored.
  - reset asserted mid-RUN: all outputs return to the reset values the next clock and the FIFO empties.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer and its response FIFO.
package puf_pkg;

  localparam int CHAL_W   = 8;
  localparam int RESP_W   = 8;
  localparam int RO_COUNT = 32;

  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_ACK_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RUN,
    CAPTURE,
    ERR
  } seq_state_t;

endpackage

// File: rtl/resp_fifo.sv
// Show-ahead synchronous FIFO holding captured PUF responses until the host link drains them.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Steps puf_serial through a run of consecutive challenges and queues each response for the host link.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int ACK_CYCLES     = DEF_ACK_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CHAL_W-1:0]   base_challenge,
  input  logic [7:0]          num_challenges,
  input  logic [RO_COUNT-1:0] enable_mask,
  output logic [CHAL_W-1:0]   puf_challenge,
  output logic [RO_COUNT-1:0] puf_enable,
  output logic                puf_reset,
  input  logic [RESP_W-1:0]   puf_response,
  input  logic                puf_done,
  output logic [RESP_W-1:0]   resp_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                busy,
  output logic                seq_done,
  output logic                timeout_err
);

  localparam int ACK_W = $clog2(ACK_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_state_t          state_q, state_d;
  logic [CHAL_W-1:0]   cur_chal_q, cur_chal_d;
  logic [7:0]          remaining_q, remaining_d;
  logic [RO_COUNT-1:0] mask_q, mask_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                seq_done_q, seq_done_d;
  logic                timeout_err_q, timeout_err_d;

  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_space;
  logic [RESP_W-1:0]      fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                   unused_fifo_count;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RESP_W)
  ) u_resp_fifo (
    .clock_i   (clock),
    .reset_i   (reset),
    .push_i    (fifo_push),
    .wr_data_i (puf_response),
    .pop_i     (resp_ready),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;
  assign fifo_space = !fifo_full || resp_ready;

  assign resp_data   = fifo_rd_data;
  assign resp_valid  = !fifo_empty;
  assign busy        = (state_q != IDLE);
  assign seq_done    = seq_done_q;
  assign timeout_err = timeout_err_q;

  // The PUF is held in reset whenever it is not actively evaluating, including the reset cycle itself.
  assign puf_reset     = reset || (state_q == IDLE) || (state_q == ACK) || (state_q == ERR);
  assign puf_enable    = ((state_q == RUN) || (state_q == CAPTURE)) ? mask_q : '0;
  assign puf_challenge = cur_chal_q;

  assign ack_cnt_d = (state_q == ACK) ? ack_cnt_q + ACK_W'(1) : '0;
  assign tmr_d     = (state_q == RUN) ? tmr_q + TMR_W'(1) : '0;

  always_comb begin
    state_d       = state_q;
    cur_chal_d    = cur_chal_q;
    remaining_d   = remaining_q;
    mask_d        = mask_q;
    seq_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    fifo_push     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d        = enable_mask;
          timeout_err_d = 1'b0;
          if (num_challenges == 8'd0) begin
            seq_done_d = 1'b1;
          end else begin
            cur_chal_d  = base_challenge;
            remaining_d = num_challenges;
            state_d     = ACK;
          end
        end
      end
      ACK: begin
        if (ack_cnt_q == ACK_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (puf_done) begin
          state_d = CAPTURE;
        end else if (tmr_q == TMR_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = ERR;
        end
      end
      // With no room the response stays held because the PUF is kept out of reset.
      CAPTURE: begin
        if (fifo_space) begin
          fifo_push = 1'b1;
          if (remaining_q == 8'd1) begin
            seq_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            remaining_d = remaining_q - 8'd1;
            cur_chal_d  = cur_chal_q + CHAL_W'(1);
            state_d     = ACK;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_chal_q    <= '0;
      remaining_q   <= '0;
      mask_q        <= '0;
      ack_cnt_q     <= '0;
      tmr_q         <= '0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_chal_q    <= cur_chal_d;
      remaining_q   <= remaining_d;
      mask_q        <= mask_d;
      ack_cnt_q     <= ack_cnt_d;
      tmr_q         <= tmr_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer driving a behavioural stand-in for puf_serial.
module tb_puf_challenge_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  base_challenge;
  logic [7:0]  num_challenges;
  logic [31:0] enable_mask;
  logic [7:0]  puf_challenge;
  logic [31:0] puf_enable;
  logic        puf_reset;
  logic [7:0]  puf_response;
  logic        puf_done;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;
  logic        seq_done;
  logic        timeout_err;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]  expQ[$];
  logic [7:0]  respByChal [256];
  int          doneDelay = 0;
  int          runCnt    = 0;

  logic [7:0]  chalSeen[$];
  logic [31:0] enSeen[$];
  int          ackLen[$];
  int          lowLen[$];
  int          doneCnt;
  logic        doneBusy;

  puf_challenge_sequencer #(
    .FIFO_DEPTH     (4),
    .ACK_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .base_challenge (base_challenge),
    .num_challenges (num_challenges),
    .enable_mask    (enable_mask),
    .puf_challenge  (puf_challenge),
    .puf_enable     (puf_enable),
    .puf_reset      (puf_reset),
    .puf_response   (puf_response),
    .puf_done       (puf_done),
    .resp_data      (resp_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .busy           (busy),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Stand-in for puf_serial: raises its byte-ready level doneDelay clocks after leaving reset.
  initial begin
    puf_done     = 1'b0;
    puf_response = 8'h00;
    forever begin
      @(negedge clock);
      if (puf_reset) begin
        runCnt   = 0;
        puf_done = 1'b0;
      end else begin
        runCnt++;
        if (doneDelay != 0 && runCnt >= doneDelay) begin
          puf_done     = 1'b1;
          puf_response = respByChal[puf_challenge];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && resp_valid && resp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_response_expected", 32'd0, 32'd1);
        end else begin
          checkOutput("sb_resp_data", 32'(resp_data), 32'(expQ.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] base, input logic [7:0] num, input logic [31:0] mask);
    @(posedge clock);
    #1;
    base_challenge = base;
    num_challenges = num;
    enable_mask    = mask;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic watchRun(input int maxCycles);
    int  hiRun;
    int  lowRun;
    bit  prevLow;
    bit  finished;
    chalSeen.delete();
    enSeen.delete();
    ackLen.delete();
    lowLen.delete();
    doneCnt  = 0;
    doneBusy = 1'b1;
    hiRun    = 0;
    lowRun   = 0;
    prevLow  = 0;
    finished = 0;
    for (int c = 0; c < maxCycles && !finished; c++) begin
      @(negedge clock);
      if (seq_done) begin
        doneCnt++;
        doneBusy = busy;
      end
      if (!puf_reset) begin
        if (!prevLow) begin
          chalSeen.push_back(puf_challenge);
          enSeen.push_back(puf_enable);
          ackLen.push_back(hiRun);
          lowRun = 0;
        end
        lowRun++;
        prevLow = 1;
        hiRun   = 0;
      end else begin
        if (prevLow) lowLen.push_back(lowRun);
        prevLow = 0;
        if (busy) hiRun++;
      end
      if (!busy) finished = 1;
    end
    checkOutput("run_finished_in_budget", 32'(finished), 32'd1);
    repeat (3) begin
      @(negedge clock);
      if (seq_done) doneCnt++;
    end
  endtask

  task automatic drainFifo();
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (!resp_valid) break;
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    checkOutput("drain_empty", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int seqDoneCount;
    reset          = 1'b1;
    start          = 1'b0;
    base_challenge = 8'h00;
    num_challenges = 8'h00;
    enable_mask    = 32'h0;
    resp_ready     = 1'b0;
    for (int i = 0; i < 256; i++) respByChal[i] = 8'h00;

    @(negedge clock);
    checkOutput("puf_reset_during_reset", 32'(puf_reset), 32'd1);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_seq_done", 32'(seq_done), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_puf_challenge", 32'(puf_challenge), 32'd0);
    checkOutput("rst_puf_enable", puf_enable, 32'd0);
    checkOutput("rst_puf_reset", 32'(puf_reset), 32'd1);

    $display("[TB] single challenge");
    respByChal[8'h3C] = 8'hA5;
    doneDelay = 10;
    expQ.push_back(8'hA5);
    applyStimulus(8'h3C, 8'd1, 32'hFFFF_FFFF);
    watchRun(80);
    checkOutput("single_chal_count", 32'(chalSeen.size()), 32'd1);
    checkOutput("single_chal", (chalSeen.size() > 0) ? 32'(chalSeen[0]) : 32'hDEAD_BEEF, 32'h3C);
    checkOutput("single_enable", (enSeen.size() > 0) ? enSeen[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    checkOutput("single_ack_len", (ackLen.size() > 0) ? 32'(ackLen[0]) : 32'hDEAD_BEEF, 32'd2);
    checkOutput("single_low_len", (lowLen.size() > 0) ? 32'(lowLen[0]) : 32'hDEAD_BEEF, 32'd11);
    checkOutput("single_seq_done", 32'(doneCnt), 32'd1);
    checkOutput("single_busy_at_done", 32'(doneBusy), 32'd0);
    checkOutput("single_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("single_resp_data", 32'(resp_data), 32'hA5);
    checkOutput("single_idle_enable", puf_enable, 32'd0);
    drainFifo();

    $display("[TB] wrap and sequence");
    respByChal[8'hFE] = 8'h11;
    respByChal[8'hFF] = 8'h22;
    respByChal[8'h00] = 8'h33;
    doneDelay = 3;
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    expQ.push_back(8'h33);
    applyStimulus(8'hFE, 8'd3, 32'h0F0F_1234);
    watchRun(80);
    checkOutput("wrap_chal_count", 32'(chalSeen.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] expChal;
      expChal = 8'hFE + 8'(i);
      checkOutput($sformatf("wrap_chal%0d", i), (chalSeen.size() > i) ? 32'(chalSeen[i]) : 32'hDEAD_BEEF, 32'(expChal));
      checkOutput($sformatf("wrap_ack_len%0d", i), (ackLen.size() > i) ? 32'(ackLen[i]) : 32'hDEAD_BEEF, 32'd2);
      checkOutput($sformatf("wrap_low_len%0d", i), (lowLen.size() > i) ? 32'(lowLen[i]) : 32'hDEAD_BEEF, 32'd4);
    end
    checkOutput("wrap_seq_done", 32'(doneCnt), 32'd1);
    drainFifo();

    $display("[TB] backpressure");
    doneDelay = 2;
    for (int i = 0; i < 6; i++) begin
      respByChal[8'h10 + i] = 8'h40 + 8'(i);
      expQ.push_back(8'h40 + 8'(i));
    end
    applyStimulus(8'h10, 8'd6, 32'hA5A5_0001);
    repeat (40) @(posedge clock);
    @(negedge clock);
    checkOutput("bp_stall_busy", 32'(busy), 32'd1);
    checkOutput("bp_stall_puf_reset", 32'(puf_reset), 32'd0);
    checkOutput("bp_stall_chal", 32'(puf_challenge), 32'h14);
    checkOutput("bp_stall_enable", puf_enable, 32'hA5A5_0001);
    checkOutput("bp_stall_head", 32'(resp_data), 32'h40);
    repeat (5) @(negedge clock);
    checkOutput("bp_stall_held_chal", 32'(puf_challenge), 32'h14);
    checkOutput("bp_stall_held_reset", 32'(puf_reset), 32'd0);
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    @(negedge clock);
    checkOutput("bp_after_pop_puf_reset", 32'(puf_reset), 32'd1);
    checkOutput("bp_after_pop_chal", 32'(puf_challenge), 32'h15);
    checkOutput("bp_after_pop_head", 32'(resp_data), 32'h41);
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    watchRun(60);
    checkOutput("bp_last_chal", (chalSeen.size() > 0) ? 32'(chalSeen[0]) : 32'hDEAD_BEEF, 32'h15);
    checkOutput("bp_seq_done", 32'(doneCnt), 32'd1);
    drainFifo();

    $display("[TB] timeout");
    doneDelay = 0;
    applyStimulus(8'h80, 8'd2, 32'h8000_0001);
    watchRun(60);
    checkOutput("to_chal_count", 32'(chalSeen.size()), 32'd1);
    checkOutput("to_low_len", (lowLen.size() > 0) ? 32'(lowLen[0]) : 32'hDEAD_BEEF, 32'd16);
    checkOutput("to_seq_done", 32'(doneCnt), 32'd0);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    repeat (5) @(negedge clock);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
    checkOutput("to_idle", 32'(busy), 32'd0);

    $display("[TB] empty run");
    applyStimulus(8'h55, 8'd0, 32'h0000_0001);
    watchRun(5);
    checkOutput("zero_seq_done", 32'(doneCnt), 32'd1);
    checkOutput("zero_no_challenge", 32'(chalSeen.size()), 32'd0);
    checkOutput("zero_err_cleared", 32'(timeout_err), 32'd0);

    $display("[TB] start while busy");
    respByChal[8'h20] = 8'h77;
    doneDelay = 4;
    expQ.push_back(8'h77);
    applyStimulus(8'h20, 8'd1, 32'h00FF_00FF);
    @(posedge clock);
    #1;
    base_challenge = 8'h90;
    num_challenges = 8'd5;
    enable_mask    = 32'h1111_1111;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    watchRun(60);
    checkOutput("busy_start_chal_count", 32'(chalSeen.size()), 32'd1);
    checkOutput("busy_start_chal", (chalSeen.size() > 0) ? 32'(chalSeen[0]) : 32'hDEAD_BEEF, 32'h20);
    checkOutput("busy_start_enable", (enSeen.size() > 0) ? enSeen[0] : 32'hDEAD_BEEF, 32'h00FF_00FF);
    checkOutput("busy_start_seq_done", 32'(doneCnt), 32'd1);
    drainFifo();

    $display("[TB] reset mid-run");
    respByChal[8'h30] = 8'h99;
    doneDelay = 5;
    applyStimulus(8'h30, 8'd3, 32'h1234_5678);
    repeat (11) @(posedge clock);
    @(negedge clock);
    checkOutput("mid_pre_puf_reset", 32'(puf_reset), 32'd0);
    checkOutput("mid_pre_chal", 32'(puf_challenge), 32'h31);
    checkOutput("mid_pre_resp_valid", 32'(resp_valid), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_reset_puf_reset", 32'(puf_reset), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("mid_puf_enable", puf_enable, 32'd0);
    checkOutput("mid_puf_challenge", 32'(puf_challenge), 32'd0);
    checkOutput("mid_puf_reset", 32'(puf_reset), 32'd1);
    seqDoneCount = 0;
    repeat (4) begin
      if (seq_done) seqDoneCount++;
      @(negedge clock);
    end
    checkOutput("mid_no_seq_done", 32'(seqDoneCount), 32'd0);

    checkOutput("sb_all_consumed", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
